onehot_demux: RTL and testbench
===============================

Name: onehot_demux

Overview:
- Inverse of the one-hot channel mux: one input word stream is routed to exactly one of CHANNELS output channels, selected by a one-hot destination vector sent with the word.
- Elastic 2-entry buffer decouples the upstream producer from per-channel downstream backpressure.
- Output data uses the same packed channel layout as the mux input, so a mux/demux pair round-trips words.

Parameters:
- CHANNELS, 2, number of output channels (>=2).
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- i_ready  output  1  block can accept a word this cycle.
- i_onehot  input  CHANNELS  destination select, bit k selects channel k.
- i_data  input  WIDTH  upstream word.
- o_valid  output  CHANNELS  per-channel valid.
- o_ready  input  CHANNELS  per-channel ready.
- o_data  output  CHANNELS*WIDTH  packed; channel k occupies bits [k*WIDTH +: WIDTH].
- o_err  output  1  one-cycle pulse: an illegal select was dropped.

Behaviour:
- Storage: 2-entry FIFO of {onehot, data}. Pointers are 1 bit wide and wrap naturally. count is 0..2. Occupancy states: EMPTY(0), ONE(1), FULL(2).
- Reset, while rst=1 and in the cycle after:
  - count=0, pointers=0.
  - o_valid=0, o_data=0, o_err=0.
  - i_ready=0 while rst is high; 1 from the first cycle rst is low.
  - Reset mid-operation discards all buffered words without delivering them.
- i_ready = !rst && (count != 2). It depends only on registered state, so there is no combinational path from o_ready. When FULL, the block is not ready even if a pop occurs that cycle.
- Push: occurs on i_valid & i_ready with a legal select (exactly one bit set). Word is written at the write pointer.
- Illegal select (zero bits or more than one bit set):
  - The handshake still completes (word consumed) but nothing is stored.
  - o_err=1 on the next cycle only.
- Head outputs:
  - o_valid = (count != 0) ? head_onehot : 0.
  - o_data slot k = head_data & {WIDTH{o_valid[k]}}. Unselected slots are 0.
- Pop: occurs when (o_valid & o_ready) != 0. Read pointer advances. Ready on unselected channels is ignored.
- Latency: a word accepted in cycle N is visible on o_valid in cycle N+1 if the FIFO was empty. Otherwise it is visible after the words ahead of it are popped.
- Throughput: 1 word/cycle with simultaneous push+pop in state ONE. Count is unchanged and ordering is preserved.
- Transitions:
  - EMPTY to ONE on push.
  - ONE to FULL on push without pop.
  - ONE to EMPTY on pop without push.
  - FULL to ONE on pop.
- Push and pop in the same cycle in EMPTY is impossible, since a new word is only visible next cycle.
- Order is strictly FIFO across all channels. A stalled head blocks later words for other channels (no reordering).

Optional Feature:
- Macro: ONEHOT_DEMUX_BROADCAST_EN.
- Defined:
  - Multi-hot selects are legal; only all-zero is illegal and dropped with o_err.
  - The head word is presented on every selected channel.
  - A registered done-mask (CHANNELS bits, cleared on reset and on each pop) records channels that have handshaken.
  - o_valid = head_onehot & ~done_mask.
  - Pop occurs when (done_mask | (o_valid & o_ready)) == head_onehot. The done-mask then clears.
- Undefined: behaviour is exactly as in Behaviour above, and no done-mask logic exists.

Test Plan:
- Reset, then i_valid=1, i_onehot=2'b10, i_data=8'hA5, o_ready=2'b11 -> next cycle o_valid=2'b10, o_data=16'hA500; cycle after, o_valid=0.
- o_ready=0; push 3 words (8'h11 ch0, 8'h22 ch1, 8'h33 ch0) back to back -> i_ready drops after 2 accepts. The third word is held by upstream until the first pop; delivered order is 11, 22, 33.
- Steady stream alternating ch0/ch1, o_ready=2'b11 -> one word accepted and one delivered per cycle; count stays 1; no gaps.
- i_onehot=2'b00 with data 8'hFF, then 2'b11 with data 8'hEE (macro off) -> both consumed, o_err pulses on each following cycle, o_valid stays 0.
- Macro on: i_onehot=2'b11, data 8'h5A, o_ready=2'b01 then 2'b10 -> ch0 receives in cycle 1; ch1 receives in cycle 2; pop occurs only after cycle 2.
- FIFO FULL with o_valid=2'b01; assert rst for 1 cycle -> o_valid=0, o_data=0, i_ready=0 during reset and 1 after; pre-reset words are never delivered.

Source files
------------

// File: rtl/onehot_demux.sv
// One-hot demux: routes each {select, word} to one output channel through a 2-entry elastic FIFO.
// Latency 1 cycle when empty; upstream sees backpressure only when FULL. ONEHOT_DEMUX_BROADCAST_EN enables multi-hot fan-out.
module onehot_demux #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [CHANNELS-1:0]       i_onehot,
  input  logic [WIDTH-1:0]          i_data,
  output logic [CHANNELS-1:0]       o_valid,
  input  logic [CHANNELS-1:0]       o_ready,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic                      o_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t                occ_q, occ_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] sel_q  [2];
  logic [CHANNELS-1:0] sel_d  [2];
  logic [WIDTH-1:0]    data_q [2];
  logic [WIDTH-1:0]    data_d [2];

  logic                sel_legal;
  logic                accept;
  logic                push;
  logic                pop;
  logic                has_head;
  logic [CHANNELS-1:0] head_sel;
  logic [WIDTH-1:0]    head_data;

  assign head_sel  = sel_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign has_head  = !rst && (occ_q != EMPTY);

  // Ready comes from registered occupancy only, so no path from o_ready.
  assign i_ready = !rst && (occ_q != FULL);
  assign accept  = i_valid && i_ready;
  assign push    = accept && sel_legal;
  assign o_err   = err_q && !rst;

`ifdef ONEHOT_DEMUX_BROADCAST_EN
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] fire;

  assign sel_legal = |i_onehot;
  assign o_valid   = has_head ? (head_sel & ~done_q) : '0;
  assign fire      = o_valid & o_ready;
  assign pop       = has_head && ((done_q | fire) == head_sel);

  always_comb begin
    done_d = done_q | fire;
    if (pop) begin
      done_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end
`else
  assign sel_legal = $onehot(i_onehot);
  assign o_valid   = has_head ? head_sel : '0;
  assign pop       = |(o_valid & o_ready);
`endif

  always_comb begin
    o_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      o_data[k*WIDTH +: WIDTH] = head_data & {WIDTH{o_valid[k]}};
    end
  end

  // Occupancy FSM; a pop is impossible in EMPTY since new words surface a cycle later.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      EMPTY: begin
        if (push) begin
          occ_d = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          occ_d = FULL;
        end else if (pop && !push) begin
          occ_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          occ_d = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    err_d    = accept && !sel_legal;
    sel_d    = sel_q;
    data_d   = data_q;
    if (push) begin
      sel_d[wr_ptr_q]  = i_onehot;
      data_d[wr_ptr_q] = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        sel_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_onehot_demux.sv
// Randomised bench for onehot_demux against a queue-based reference model of the demux rules.
module tb_onehot_demux;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [1:0]  i_onehot;
  logic [7:0]  i_data;
  logic [1:0]  o_valid;
  logic [1:0]  o_ready;
  logic [15:0] o_data;
  logic        o_err;

  int vectors = 0;
  int miscompares = 0;

  onehot_demux #(.CHANNELS(2), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_onehot(i_onehot), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] sel;
    logic [7:0] dat;
  } ent_t;

  ent_t        mq[$];
  logic        m_err = 1'b0;
  logic [1:0]  m_done = 2'b00;

  logic        e_ready;
  logic [1:0]  e_valid;
  logic [15:0] e_data;
  logic        e_err;

  function automatic logic legal(input logic [1:0] sel);
`ifdef ONEHOT_DEMUX_BROADCAST_EN
    return sel != 2'b00;
`else
    return $countones(sel) == 1;
`endif
  endfunction

  function automatic logic [19:0] obs();
    return {i_ready, o_valid, o_data, o_err};
  endfunction

  function automatic logic [19:0] exp_all();
    return {e_ready, e_valid, e_data, e_err};
  endfunction

  task automatic calc_exp();
    e_ready = !rst && (mq.size() < 2);
    e_valid = (rst || mq.size() == 0) ? 2'b00 : (mq[0].sel & ~m_done);
    e_data  = 16'h0;
    for (int k = 0; k < 2; k++) begin
      if (e_valid[k]) e_data[k*8 +: 8] = mq[0].dat;
    end
    e_err = !rst && m_err;
  endtask

  // A word leaves once every channel it selects has handshaken.
  task automatic model_tick();
    logic       acc;
    logic       pop;
    logic [1:0] fire;
    if (rst) begin
      mq.delete();
      m_err  = 1'b0;
      m_done = 2'b00;
      return;
    end
    calc_exp();
    acc  = i_valid && e_ready;
    fire = e_valid & o_ready;
    pop  = (mq.size() > 0) && ((m_done | fire) == mq[0].sel);
    m_done = pop ? 2'b00 : (m_done | fire);
    if (pop) void'(mq.pop_front());
    if (acc && legal(i_onehot)) mq.push_back('{sel: i_onehot, dat: i_data});
    m_err = acc && !legal(i_onehot);
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_onehot = 2'b00; i_data = 8'h00; o_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1; i_onehot = 2'($urandom); i_data = 8'($urandom); o_ready = 2'($urandom);
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h want %h", c, obs(), exp_all());
      end
      vectors++;
      if (i_ready !== 1'b0 || o_valid !== 2'b00 || o_data !== 16'h0 || o_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_const c%0d: got rdy=%b vld=%b dat=%h err=%b want all zero", c, i_ready, o_valid, o_data, o_err);
      end
      advance();
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (i_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 1", i_ready);
    end
    advance();
  endtask

  task automatic test_single();
    for (int c = 0; c < 3; c++) begin
      i_valid = (c == 0); i_onehot = 2'b10; i_data = 8'hA5; o_ready = 2'b11;
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL single c%0d: got %h want %h", c, obs(), exp_all());
      end
      if (c == 1) begin
        vectors++;
        if (o_valid !== 2'b10 || o_data !== 16'hA500) begin
          miscompares++;
          $display("FAIL single_word: got vld=%b dat=%h want vld=10 dat=a500", o_valid, o_data);
        end
      end
      if (c == 2) begin
        vectors++;
        if (o_valid !== 2'b00) begin
          miscompares++;
          $display("FAIL single_drained: got vld=%b want 00", o_valid);
        end
      end
      advance();
    end
  endtask

  task automatic test_fill();
    logic [1:0] sels [3];
    logic [7:0] dats [3];
    logic [7:0] got[$];
    int idx = 0;
    sels[0] = 2'b01; sels[1] = 2'b10; sels[2] = 2'b01;
    dats[0] = 8'h11; dats[1] = 8'h22; dats[2] = 8'h33;
    for (int c = 0; c < 10; c++) begin
      i_valid  = (idx < 3);
      i_onehot = (idx < 3) ? sels[idx] : 2'b00;
      i_data   = (idx < 3) ? dats[idx] : 8'h00;
      o_ready  = (c >= 4) ? 2'b11 : 2'b00;
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL fill c%0d: got %h want %h", c, obs(), exp_all());
      end
      if (c == 2 || c == 4) begin
        vectors++;
        if (i_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_full c%0d: got rdy=%b want 0", c, i_ready);
        end
      end
      if ((o_valid & o_ready) != 2'b00) got.push_back(o_valid[1] ? o_data[15:8] : o_data[7:0]);
      if (i_valid && i_ready) idx++;
      advance();
    end
    vectors++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      miscompares++;
      $display("FAIL fill_order: got %0d words %p want 11 22 33", got.size(), got);
    end
  endtask

  task automatic test_stream();
    for (int c = 0; c < 18; c++) begin
      i_valid = (c < 16); i_onehot = c[0] ? 2'b10 : 2'b01; i_data = 8'($urandom); o_ready = 2'b11;
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL stream c%0d: got %h want %h", c, obs(), exp_all());
      end
      if (c >= 1 && c <= 16) begin
        vectors++;
        if (o_valid === 2'b00 || i_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_gap c%0d: got vld=%b rdy=%b want nonzero/1", c, o_valid, i_ready);
        end
      end
      advance();
    end
  endtask

  task automatic test_illegal();
    for (int c = 0; c < 4; c++) begin
      i_valid = (c < 2); i_onehot = (c == 0) ? 2'b00 : 2'b11;
      i_data = (c == 0) ? 8'hFF : 8'hEE; o_ready = 2'b00;
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL illegal c%0d: got %h want %h", c, obs(), exp_all());
      end
`ifndef ONEHOT_DEMUX_BROADCAST_EN
      vectors++;
      if (o_err !== (c == 1 || c == 2) || o_valid !== 2'b00) begin
        miscompares++;
        $display("FAIL illegal_err c%0d: got err=%b vld=%b want err=%b vld=00", c, o_err, o_valid, (c == 1 || c == 2));
      end
`endif
      advance();
    end
    // Drain anything that was legal under broadcast.
    for (int c = 0; c < 3; c++) begin
      idle_inputs(); o_ready = 2'b11;
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL illegal_drain c%0d: got %h want %h", c, obs(), exp_all());
      end
      advance();
    end
  endtask

`ifdef ONEHOT_DEMUX_BROADCAST_EN
  task automatic test_broadcast();
    for (int c = 0; c < 4; c++) begin
      i_valid = (c == 0); i_onehot = 2'b11; i_data = 8'h5A;
      o_ready = (c == 1) ? 2'b01 : ((c == 2) ? 2'b10 : 2'b00);
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL bcast c%0d: got %h want %h", c, obs(), exp_all());
      end
      if (c == 2) begin
        vectors++;
        if (o_valid !== 2'b10 || o_data !== 16'h5A00) begin
          miscompares++;
          $display("FAIL bcast_second: got vld=%b dat=%h want vld=10 dat=5a00", o_valid, o_data);
        end
      end
      advance();
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      i_valid = ($urandom_range(0, 3) != 0); i_onehot = 2'($urandom); i_data = 8'($urandom);
      o_ready = 2'($urandom);
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", c, obs(), exp_all());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1; i_onehot = 2'b01; i_data = 8'h40 + 8'(c); o_ready = 2'b00;
      #1; calc_exp();
      vectors++;
      if (obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL midrst_fill c%0d: got %h want %h", c, obs(), exp_all());
      end
      advance();
    end
    rst = 1'b1; idle_inputs();
    #1; calc_exp();
    vectors++;
    if (o_valid !== 2'b00 || o_data !== 16'h0 || i_ready !== 1'b0 || obs() !== exp_all()) begin
      miscompares++;
      $display("FAIL midrst_during: got %h want %h", obs(), exp_all());
    end
    advance();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle_inputs(); o_ready = 2'b11;
      #1; calc_exp();
      vectors++;
      if (o_valid !== 2'b00 || i_ready !== 1'b1 || obs() !== exp_all()) begin
        miscompares++;
        $display("FAIL midrst_after c%0d: got %h want %h", c, obs(), exp_all());
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_illegal();
`ifdef ONEHOT_DEMUX_BROADCAST_EN
    test_broadcast();
`endif
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
